exec_stage: RTL and testbench
=============================

// Module: exec_stage
// PURPOSE
//  Execute stage directly downstream of the 8x8 register file.
//  Consumes both read ports plus decoded op/rd/rs fields and computes an ALU or multi-cycle MUL result.
//  Returns the result to the file's write port (wb_en/wb_addr/wb_data).
//  Bypasses its own in-flight writeback, since a write landing on the same edge as an async read returns a stale value.
// PARAMETERS
//  DATA_WIDTH      8  operand/result width; also the MUL iteration count
//  REG_ADDR_WIDTH  3  register index width (2**REG_ADDR_WIDTH registers; index 0 is hardwired zero)
// PORTS
//  clk        in   1   single clock; all state on posedge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   decoded instruction present
//  in_ready   out  1   stage can accept; = (state==IDLE)
//  in_op      in   3   alu_op_t: ADD,SUB,AND,ORR,EOR,LSL,LSR,MUL
//  in_rd      in   3   destination register
//  in_rs1     in   3   source 1 index (for bypass compare)
//  in_rs2     in   3   source 2 index (for bypass compare)
//  in_op1     in   8   register-file read_data1
//  in_op2     in   8   register-file read_data2
//  in_imm     in   8   immediate
//  in_use_imm in   1   1: operand B = in_imm, rs2 bypass ignored
//  wb_en      out  1   write strobe to register file, one cycle per result
//  wb_addr    out  3   destination index
//  wb_data    out  8   result
//  flag_z     out  1   result==0 of last completed op
//  flag_c     out  1   carry of last completed op
// BEHAVIOUR
//  Reset: state=IDLE, wb_en=0, wb_addr=0, wb_data=0, flag_z=0, flag_c=0, MUL counter=0; in_ready=1 after release.
//  Accept = in_valid && in_ready. Outputs are registered.
//  Bypass, evaluated in the accept cycle:
//   - A = (wb_en && wb_addr==in_rs1 && in_rs1!=0) ? wb_data : in_op1.
//   - Same rule for B with in_rs2 and in_op2, unless in_use_imm.
//   - rs==0 always takes the port value (RF returns 0).
//  Single-cycle ops (ADD..LSR), accepted in cycle T:
//   - wb_en=1 in T+1, result on wb_data; state stays IDLE.
//   - Back-to-back accepts produce one writeback per cycle.
//  Arithmetic, all modulo 2**DATA_WIDTH:
//   - ADD: c = carry-out.
//   - SUB: A-B, c = no-borrow (A>=B unsigned).
//   - AND/ORR/EOR: c=0.
//   - LSL/LSR: shift amount = B[2:0], zero fill, c = last bit shifted out (0 when amount is 0).
//   - MUL: low DATA_WIDTH bits of A*B, c = 1 if the high half is nonzero.
//  MUL FSM: IDLE -> MUL -> IDLE.
//   - Accept in T latches A, B and rd, then enters MUL.
//   - One shift-add iteration per cycle for DATA_WIDTH cycles (T+1..T+8).
//   - On the last iteration returns to IDLE with wb_en=1 in T+9. in_ready=0 in T+1..T+8.
//   - An instruction accepted in T+9 sees the MUL result via bypass.
//  wb_en is a single-cycle pulse; it deasserts the cycle after any writeback unless a new op completes.
//  rd==0: result computed and flags updated; wb_en held 0, wb_addr/wb_data still updated.
//  Flags update only on the cycle a result completes; otherwise they hold.
//  in_valid while in_ready=0: ignored, no side effects; upstream must hold the instruction.
//  Reset mid-MUL: abort immediately, no writeback, flags cleared, IDLE.
// STRUCTURE
//  legv8_pkg:
//   - DATA_WIDTH and REG_ADDR_WIDTH localparams.
//   - alu_op_t enum (3 bits: ADD=0,SUB=1,AND=2,ORR=3,EOR=4,LSL=5,LSR=6,MUL=7).
//   - exec_state_t enum {IDLE,MUL}.
//  Sub-module alu_comb: purely combinational A/B/op -> result, carry for ADD..LSR.
//  The bypass muxes, MUL datapath (multiplicand, multiplier, accumulator, counter), FSM and output registers stay in exec_stage.
// TESTING
//  1 Reset: assert rst mid-stream -> all outputs 0, in_ready=1 on release.
//  2 ADD: R1 op1=0xF0, imm=0x20, rd=2 -> next cycle wb_en=1, wb_addr=2, wb_data=0x10, c=1, z=0.
//  3 Bypass chain:
//     - ADD rd=3 (0x05+0x01); next cycle SUB rd=4, rs1=3, port op1 stale=0x00, op2=0x06.
//     - -> wb_data=0x00, z=1, c=1.
//  4 MUL 0x13*0x0E, rd=5 -> in_ready low 8 cycles, wb at T+9 = 0x0A, c=1.
//     - in_valid held during busy is not accepted early.
//  5 rd=0 EOR 0xAA^0xAA -> wb_en stays 0, z=1.
//     - rs1=0 with wb_addr=0 pending -> no bypass.
//  6 LSR 0x81 by 1 -> 0x40, c=1; LSL by 0 -> unchanged, c=0.
//     - rst pulsed at MUL cycle 4 -> no wb_en afterwards.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types and widths for the LEGv8 execute slice.
package legv8_pkg;
  localparam int DATA_WIDTH     = 8;
  localparam int REG_ADDR_WIDTH = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_EOR = 3'd4,
    ALU_LSL = 3'd5,
    ALU_LSR = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_t;
endpackage

// File: rtl/exec_stage_alu_comb.sv
// Single-cycle ALU: result and carry for ADD..LSR.
module alu_comb
  import legv8_pkg::*;
(
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  carry
);
  logic [DATA_WIDTH:0] sum_w;
  logic [DATA_WIDTH:0] dif_w;
  logic [DATA_WIDTH:0] lsl_w;
  logic [DATA_WIDTH:0] lsr_w;
  logic [2:0]          shamt;

  always_comb begin
    shamt = b[2:0];
    sum_w = {1'b0, a} + {1'b0, b};
    dif_w = {1'b0, a} - {1'b0, b};
    // extra bit catches the last bit shifted out
    lsl_w = {1'b0, a} << shamt;
    lsr_w = {a, 1'b0} >> shamt;
    res   = '0;
    carry = 1'b0;
    unique case (op)
      ALU_ADD: begin
        res   = sum_w[DATA_WIDTH-1:0];
        carry = sum_w[DATA_WIDTH];
      end
      ALU_SUB: begin
        res   = dif_w[DATA_WIDTH-1:0];
        carry = ~dif_w[DATA_WIDTH];
      end
      ALU_AND: res = a & b;
      ALU_ORR: res = a | b;
      ALU_EOR: res = a ^ b;
      ALU_LSL: begin
        res   = lsl_w[DATA_WIDTH-1:0];
        carry = lsl_w[DATA_WIDTH];
      end
      ALU_LSR: begin
        res   = lsr_w[DATA_WIDTH:1];
        carry = lsr_w[0];
      end
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/exec_stage.sv
// Execute stage: bypassed ALU plus shift-add multiplier, writing back
// to the register file.
module exec_stage
  import legv8_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0]     in_op1,
  input  logic [DATA_WIDTH-1:0]     in_op2,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_use_imm,
  output logic                      wb_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      flag_z,
  output logic                      flag_c
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int DW2 = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  exec_state_t state_q, state_d;
  logic wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic [DW2-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DW2-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0] mrd_q, mrd_d;

  alu_op_t op;
  logic accept;
  logic byp1, byp2;
  logic [DATA_WIDTH-1:0] opa, opb, alu_res;
  logic alu_c;
  logic [DW2-1:0] acc_nx;

  assign op       = alu_op_t'(in_op);
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // forward our own pending writeback; the RF read is stale this cycle
  assign byp1 = wb_en_q && (wb_addr_q == in_rs1) && (in_rs1 != '0);
  assign byp2 = wb_en_q && (wb_addr_q == in_rs2) && (in_rs2 != '0);
  assign opa  = byp1 ? wb_data_q : in_op1;
  assign opb  = in_use_imm ? in_imm : (byp2 ? wb_data_q : in_op2);

  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  alu_comb u_alu (
    .op    (op),
    .a     (opa),
    .b     (opb),
    .res   (alu_res),
    .carry (alu_c)
  );

  always_comb begin
    state_d   = state_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mrd_d     = mrd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && op == ALU_MUL) begin
          mcand_d  = {{DATA_WIDTH{1'b0}}, opa};
          mplier_d = opb;
          acc_d    = '0;
          cnt_d    = '0;
          mrd_d    = in_rd;
          state_d  = ST_MUL;
        end else if (accept) begin
          wb_en_d   = (in_rd != '0);
          wb_addr_d = in_rd;
          wb_data_d = alu_res;
          flag_z_d  = (alu_res == '0);
          flag_c_d  = alu_c;
        end
      end
      ST_MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          wb_en_d   = (mrd_q != '0);
          wb_addr_d = mrd_q;
          wb_data_d = acc_nx[DATA_WIDTH-1:0];
          flag_z_d  = (acc_nx[DATA_WIDTH-1:0] == '0);
          flag_c_d  = |acc_nx[DW2-1:DATA_WIDTH];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mrd_q     <= '0;
    end else begin
      state_q   <= state_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mrd_q     <= mrd_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed ops, bypass, MUL timing, reset.
module tb_exec_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = '0;
  logic [2:0] in_rd = '0;
  logic [2:0] in_rs1 = '0;
  logic [2:0] in_rs2 = '0;
  logic [7:0] in_op1 = '0;
  logic [7:0] in_op2 = '0;
  logic [7:0] in_imm = '0;
  logic       in_use_imm = 1'b0;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       flag_z;
  logic       flag_c;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, ORR = 3'd3;
  localparam logic [2:0] EOR = 3'd4, LSL = 3'd5, LSR = 3'd6, MUL = 3'd7;

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];

  exec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_op1(in_op1), .in_op2(in_op2),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d,
                      input logic z, input logic c);
    exp_q.push_back({a, d, z, c});
  endtask

  // monitor: every writeback strobe must match the oldest expectation
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst && wb_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb actual=%0h/%0h required=none",
                 wb_addr, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", int'(wb_addr), int'(e[12:10]));
        chk("wb_data", int'(wb_data), int'(e[9:2]));
        chk("flag_z", int'(flag_z), int'(e[1]));
        chk("flag_c", int'(flag_c), int'(e[0]));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] imm, input logic ui);
    int n;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_op1 = a; in_op2 = b; in_imm = imm; in_use_imm = ui;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=busy required=ready");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_wb_en", int'(wb_en), 0);
    chk("rst_wb_addr", int'(wb_addr), 0);
    chk("rst_wb_data", int'(wb_data), 0);
    chk("rst_flags", int'({flag_z, flag_c}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);

    push(3'd2, 8'h10, 1'b0, 1'b1);
    send(ADD, 3'd2, 3'd1, 3'd0, 8'hF0, 8'h00, 8'h20, 1'b1);

    push(3'd3, 8'h06, 1'b0, 1'b0);
    send(ADD, 3'd3, 3'd6, 3'd7, 8'h05, 8'h01, 8'h00, 1'b0);
    push(3'd4, 8'h00, 1'b1, 1'b1);
    send(SUB, 3'd4, 3'd3, 3'd7, 8'h00, 8'h06, 8'h00, 1'b0);

    // MUL; a held ADD must wait and then see the product via bypass
    push(3'd5, 8'h0A, 1'b0, 1'b1);
    push(3'd6, 8'h0B, 1'b0, 1'b0);
    send(MUL, 3'd5, 3'd6, 3'd7, 8'h13, 8'h0E, 8'h00, 1'b0);
    in_op = ADD; in_rd = 3'd6; in_rs1 = 3'd5; in_rs2 = 3'd7;
    in_op1 = 8'h00; in_op2 = 8'h00; in_imm = 8'h01; in_use_imm = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("mul_busy%0d", i), int'(in_ready), 0);
    end
    @(negedge clk);
    chk("mul_done_ready", int'(in_ready), 1);
    chk("mul_done_wb", int'(wb_en), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;

    send(EOR, 3'd0, 3'd1, 3'd0, 8'hAA, 8'h00, 8'hAA, 1'b1);
    @(negedge clk);
    chk("rd0_wb_en", int'(wb_en), 0);
    chk("rd0_z", int'(flag_z), 1);
    chk("rd0_c", int'(flag_c), 0);
    chk("rd0_addr", int'(wb_addr), 0);
    push(3'd1, 8'h33, 1'b0, 1'b0);
    send(ORR, 3'd1, 3'd0, 3'd2, 8'h00, 8'h00, 8'h33, 1'b1);

    push(3'd1, 8'h40, 1'b0, 1'b1);
    send(LSR, 3'd1, 3'd2, 3'd3, 8'h81, 8'h00, 8'h01, 1'b1);
    push(3'd2, 8'h81, 1'b0, 1'b0);
    send(LSL, 3'd2, 3'd3, 3'd4, 8'h81, 8'h00, 8'h00, 1'b1);
    push(3'd3, 8'h81, 1'b0, 1'b0);
    send(AND_, 3'd3, 3'd4, 3'd2, 8'hC3, 8'h00, 8'h00, 1'b0);
    push(3'd7, 8'h00, 1'b1, 1'b1);
    send(ADD, 3'd7, 3'd6, 3'd0, 8'hFF, 8'h00, 8'h01, 1'b1);
    push(3'd6, 8'hFF, 1'b0, 1'b0);
    send(SUB, 3'd6, 3'd5, 3'd4, 8'h01, 8'h02, 8'h00, 1'b0);
    push(3'd5, 8'h02, 1'b0, 1'b1);
    send(LSL, 3'd5, 3'd1, 3'd0, 8'h81, 8'h00, 8'h01, 1'b1);

    // reset during MUL iteration 4 must abort without writeback
    send(MUL, 3'd5, 3'd1, 3'd2, 8'h03, 8'h04, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_wb_en", int'(wb_en), 0);
    chk("abort_flags", int'({flag_z, flag_c}), 0);
    chk("abort_data", int'(wb_data), 0);
    chk("abort_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (wb_en) seen = 1'b1;
    end
    chk("abort_no_wb", int'(seen), 0);
    chk("abort_ready_after", int'(in_ready), 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
